// File: rtl/spi_cmd_responder.sv
// spi_cmd_responder: SPI-slave (mode 0, MSB first) command responder.
// Takes 4-byte frames (addr_msb, addr_lsb, instruction, data), one byte per
// SS window, and issues single-cycle write strobes or a one-byte read on MISO.
// Everything runs on system_clock; SCLK/MOSI/SS are oversampled.
// Optional build macro: SPI_TIMEOUT_EN enables the inter-byte SS-high timeout.
module spi_cmd_responder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              system_clock,
    input  logic              rst,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              SS,
    output logic              MISO,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              clk_div_we,
    output logic              spike_we,
    output logic              debug_we,
    output logic              rd_req,
    input  logic [7:0]        rd_data,
    output logic              spi_instruction_done,
    output logic              frame_error
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("spi_cmd_responder: illegal parameter value");
    end

    localparam logic [7:0] OP_READ   = 8'h00;
    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_CLKDIV = 8'h05;
    localparam logic [7:0] OP_SPIKE  = 8'h07;
    localparam logic [7:0] OP_DEBUG  = 8'h09;

    typedef enum logic [2:0] {
        S_MSB,
        S_LSB,
        S_INSTR,
        S_DATA,
        S_EXEC
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, ss_rise, ss_fall;

    logic [3:0]        bit_cnt_q;
    logic [7:0]        rx_q;
    logic [7:0]        tx_q;
    logic [7:0]        op_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              rd_req_q, rd_ld_q;
    logic              frame_error_q;
    logic              byte_ok, byte_bad;
    logic              op_known;
    logic              read_window;
    logic              timeout;

    logic mem_we_d, clk_div_we_d, spike_we_d, debug_we_d, done_d;
    logic mem_we_q, clk_div_we_q, spike_we_q, debug_we_q, done_q;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;

    assign byte_ok  = ss_rise && (bit_cnt_q == 4'd8);
    assign byte_bad = ss_rise && (bit_cnt_q != 4'd8);

    assign op_known = (op_q == OP_READ) || (op_q == OP_WRITE) || (op_q == OP_CLKDIV) ||
                      (op_q == OP_SPIKE) || (op_q == OP_DEBUG);

    assign read_window = (state_q == S_DATA) && (op_q == OP_READ) && !ss_s;

    // Input synchronisers and edge-detect history; SS idles high.
    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

`ifdef SPI_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // Inter-byte inactivity counter; only runs mid-frame while SS is high.
    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_MSB || ss_fall) begin
            tmo_cnt_q <= '0;
        end else if (ss_s && !timeout) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign timeout = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // Bit deserialiser, field capture, read fetch and MISO shifter.
    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            bit_cnt_q     <= '0;
            rx_q          <= '0;
            tx_q          <= '0;
            op_q          <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd_req_q      <= 1'b0;
            rd_ld_q       <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            if (ss_rise) begin
                bit_cnt_q <= '0;
            end else if (sclk_rise && !ss_s && bit_cnt_q != 4'd8) begin
                rx_q      <= {rx_q[6:0], mosi_s};
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end

            if (byte_ok && state_q == S_LSB && !timeout) begin
                mem_addr_q <= ADDR_W'(rx_q);
            end
            if (byte_ok && state_q == S_INSTR && !timeout) begin
                op_q <= rx_q;
            end
            if (byte_ok && state_q == S_DATA && !timeout) begin
                mem_wdata_q <= rx_q;
            end

            // rd_data is valid the cycle after rd_req, so load one cycle later.
            rd_req_q <= byte_ok && !timeout && (state_q == S_INSTR) && (rx_q == OP_READ);
            rd_ld_q  <= rd_req_q;

            if (rd_ld_q) begin
                tx_q <= rd_data;
            end else if (sclk_rise && read_window) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end

            if (byte_bad || timeout || (state_q == S_EXEC && !op_known)) begin
                frame_error_q <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            state_q <= S_MSB;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one step per accepted byte, abort on bad byte or timeout.
    always_comb begin
        state_d = state_q;
        if (timeout || byte_bad) begin
            state_d = S_MSB;
        end else begin
            case (state_q)
                S_MSB:   if (byte_ok) state_d = S_LSB;
                S_LSB:   if (byte_ok) state_d = S_INSTR;
                S_INSTR: if (byte_ok) state_d = S_DATA;
                S_DATA:  if (byte_ok) state_d = S_EXEC;
                S_EXEC:  state_d = S_MSB;
                default: state_d = S_MSB;
            endcase
        end
    end

    // FSM outputs: decoded strobe and done in S_EXEC, MISO during a read data byte.
    always_comb begin
        mem_we_d     = 1'b0;
        clk_div_we_d = 1'b0;
        spike_we_d   = 1'b0;
        debug_we_d   = 1'b0;
        done_d       = 1'b0;
        MISO         = read_window ? tx_q[7] : 1'b0;
        if (state_q == S_EXEC) begin
            done_d = 1'b1;
            case (op_q)
                OP_WRITE:  mem_we_d     = 1'b1;
                OP_CLKDIV: clk_div_we_d = 1'b1;
                OP_SPIKE:  spike_we_d   = 1'b1;
                OP_DEBUG:  debug_we_d   = 1'b1;
                default:   ;
            endcase
        end
    end

    // Registered strobe outputs.
    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            mem_we_q     <= 1'b0;
            clk_div_we_q <= 1'b0;
            spike_we_q   <= 1'b0;
            debug_we_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            mem_we_q     <= mem_we_d;
            clk_div_we_q <= clk_div_we_d;
            spike_we_q   <= spike_we_d;
            debug_we_q   <= debug_we_d;
            done_q       <= done_d;
        end
    end

    assign mem_addr             = mem_addr_q;
    assign mem_wdata            = mem_wdata_q;
    assign mem_we               = mem_we_q;
    assign clk_div_we           = clk_div_we_q;
    assign spike_we             = spike_we_q;
    assign debug_we             = debug_we_q;
    assign rd_req               = rd_req_q;
    assign spi_instruction_done = done_q;
    assign frame_error          = frame_error_q;

endmodule

// File: tb/tb_spi_cmd_responder.sv
// Testbench for spi_cmd_responder: SPI host model plus a scoreboard of
// expected strobe events checked by a negedge monitor.
module tb_spi_cmd_responder;

    localparam int HALF = 4;
    localparam int GAP  = 8;

    logic       system_clock = 1'b0;
    logic       rst  = 1'b1;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       SS   = 1'b1;
    logic       MISO;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we, clk_div_we, spike_we, debug_we, rd_req;
    logic [7:0] rd_data = 8'h00;
    logic       spi_instruction_done, frame_error;

    logic [7:0] mem_model [0:255];

    int n_checks   = 0;
    int n_fail     = 0;
    int rd_req_cnt = 0;

    typedef struct {
        logic [3:0] stb;   // {mem_we, clk_div_we, spike_we, debug_we}
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t sb[$];
    ev_t mon_ev;

    spi_cmd_responder #(
        .SYNC_STAGES   (2),
        .ADDR_W        (8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .system_clock        (system_clock),
        .rst                 (rst),
        .SCLK                (SCLK),
        .MOSI                (MOSI),
        .SS                  (SS),
        .MISO                (MISO),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_we              (mem_we),
        .clk_div_we          (clk_div_we),
        .spike_we            (spike_we),
        .debug_we            (debug_we),
        .rd_req              (rd_req),
        .rd_data             (rd_data),
        .spi_instruction_done(spi_instruction_done),
        .frame_error         (frame_error)
    );

    always #5 system_clock = ~system_clock;

    // Memory model: registered read, data valid the cycle after rd_req.
    always @(posedge system_clock) begin
        if (rd_req) rd_data <= mem_model[mem_addr];
    end

    // Monitor: every strobe/done cycle must match the next expected event.
    always @(negedge system_clock) begin
        if (!rst) begin
            if (rd_req) rd_req_cnt++;
            if (spi_instruction_done || mem_we || clk_div_we || spike_we || debug_we) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got stb=%b done=%b addr=%h data=%h, required no event",
                             {mem_we, clk_div_we, spike_we, debug_we}, spi_instruction_done,
                             mem_addr, mem_wdata);
                end else begin
                    mon_ev = sb.pop_front();
                    if ({mem_we, clk_div_we, spike_we, debug_we} !== mon_ev.stb ||
                        spi_instruction_done !== 1'b1 ||
                        mem_addr !== mon_ev.addr || mem_wdata !== mon_ev.data) begin
                        n_fail++;
                        $display("FAIL sb_event: got stb=%b done=%b addr=%h data=%h, required stb=%b done=1 addr=%h data=%h",
                                 {mem_we, clk_div_we, spike_we, debug_we}, spi_instruction_done,
                                 mem_addr, mem_wdata, mon_ev.stb, mon_ev.addr, mon_ev.data);
                    end
                end
            end
        end
    end

    // One SS window; extra clocks beyond 8 shift in 1s. Returns bits seen on MISO.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        logic [7:0] sh;
        sh = tx;
        rx = '0;
        @(negedge system_clock);
        SS = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = sh[7];
            sh   = {sh[6:0], 1'b1};
            repeat (HALF) @(negedge system_clock);
            SCLK = 1'b1;
            rx   = {rx[6:0], MISO};
            repeat (HALF) @(negedge system_clock);
            SCLK = 1'b0;
        end
        repeat (HALF) @(negedge system_clock);
        SS   = 1'b1;
        MOSI = 1'b0;
        repeat (GAP) @(negedge system_clock);
    endtask

    task automatic spi_frame(input logic [7:0] b0, b1, b2, b3, output logic [7:0] rx_data);
        logic [7:0] r;
        spi_byte(b0, 8, r);
        spi_byte(b1, 8, r);
        spi_byte(b2, 8, r);
        spi_byte(b3, 8, rx_data);
    endtask

    task automatic do_reset();
        @(negedge system_clock);
        rst  = 1'b1;
        SS   = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        repeat (3) @(negedge system_clock);
        rst = 1'b0;
        repeat (4) @(negedge system_clock);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge system_clock);
        n_checks++;
        if ({MISO, mem_we, clk_div_we, spike_we, debug_we, rd_req, spi_instruction_done, frame_error} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 00000000",
                     {MISO, mem_we, clk_div_we, spike_we, debug_we, rd_req, spi_instruction_done, frame_error});
        end
        n_checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%h data=%h, required 00/00", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        repeat (4) @(negedge system_clock);
        n_checks++;
        if (frame_error !== 1'b0 || MISO !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got err=%b miso=%b, required 0/0", frame_error, MISO);
        end
    endtask

    task automatic test_write();
        logic [7:0] rx;
        sb.push_back('{4'b1000, 8'h34, 8'hA5});
        spi_frame(8'h12, 8'h34, 8'h01, 8'hA5, rx);
        repeat (GAP) @(negedge system_clock);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL write_drain: got %0d pending events, required 0", sb.size());
        end
        n_checks++;
        if (rx !== 8'h00) begin
            n_fail++;
            $display("FAIL write_miso_idle: got %h, required 00", rx);
        end
        n_checks++;
        if (mem_addr !== 8'h34 || mem_wdata !== 8'hA5 || frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL write_hold: got addr=%h data=%h err=%b, required 34/A5/0", mem_addr, mem_wdata, frame_error);
        end
    endtask

    task automatic test_strobes();
        logic [7:0] rx;
        logic [7:0] addrs [3] = '{8'h06, 8'h01, 8'hA3};
        logic [7:0] ops   [3] = '{8'h05, 8'h07, 8'h09};
        logic [7:0] datas [3] = '{8'hB6, 8'hDC, 8'hD8};
        logic [3:0] stbs  [3] = '{4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{stbs[i], addrs[i], datas[i]});
            spi_frame(8'h00, addrs[i], ops[i], datas[i], rx);
        end
        repeat (GAP) @(negedge system_clock);
        n_checks++;
        if (sb.size() != 0 || frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL strobes_drain: got pending=%0d err=%b, required 0/0", sb.size(), frame_error);
        end
    endtask

    task automatic test_read();
        logic [7:0] rx;
        int         cnt0;
        mem_model[8'h34] = 8'h3C;
        cnt0 = rd_req_cnt;
        sb.push_back('{4'b0000, 8'h34, 8'h00});
        spi_frame(8'h45, 8'h34, 8'h00, 8'h00, rx);
        repeat (GAP) @(negedge system_clock);
        n_checks++;
        if (rx !== 8'h3C) begin
            n_fail++;
            $display("FAIL read_miso: got %h, required 3C", rx);
        end
        n_checks++;
        if (rd_req_cnt - cnt0 != 1) begin
            n_fail++;
            $display("FAIL read_req_count: got %0d, required 1", rd_req_cnt - cnt0);
        end
        n_checks++;
        if (sb.size() != 0 || frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL read_drain: got pending=%0d err=%b, required 0/0", sb.size(), frame_error);
        end
    endtask

    task automatic test_short_byte();
        logic [7:0] rx;
        do_reset();
        spi_byte(8'h00, 0, rx);
        n_checks++;
        if (frame_error !== 1'b1) begin
            n_fail++;
            $display("FAIL bare_ss_error: got %b, required 1", frame_error);
        end
        do_reset();
        spi_byte(8'h00, 8, rx);
        spi_byte(8'h34, 5, rx);
        n_checks++;
        if (frame_error !== 1'b1) begin
            n_fail++;
            $display("FAIL short_byte_error: got %b, required 1", frame_error);
        end
        sb.push_back('{4'b1000, 8'h10, 8'h77});
        spi_frame(8'h00, 8'h10, 8'h01, 8'h77, rx);
        repeat (GAP) @(negedge system_clock);
        n_checks++;
        if (sb.size() != 0 || mem_addr !== 8'h10 || mem_wdata !== 8'h77) begin
            n_fail++;
            $display("FAIL short_recover: got pending=%0d addr=%h data=%h, required 0/10/77", sb.size(), mem_addr, mem_wdata);
        end
        n_checks++;
        if (frame_error !== 1'b1) begin
            n_fail++;
            $display("FAIL error_sticky: got %b, required 1", frame_error);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] rx;
        do_reset();
        sb.push_back('{4'b1000, 8'h5C, 8'hC3});
        spi_byte(8'h00, 8, rx);
        spi_byte(8'h5C, 8, rx);
        spi_byte(8'h01, 8, rx);
        spi_byte(8'hC3, 10, rx);
        repeat (GAP) @(negedge system_clock);
        n_checks++;
        if (sb.size() != 0 || mem_wdata !== 8'hC3 || frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL saturation: got pending=%0d data=%h err=%b, required 0/C3/0", sb.size(), mem_wdata, frame_error);
        end
    endtask

    task automatic test_unknown_opcode();
        logic [7:0] rx;
        sb.push_back('{4'b0000, 8'h22, 8'h5A});
        spi_frame(8'h00, 8'h22, 8'h03, 8'h5A, rx);
        repeat (GAP) @(negedge system_clock);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL unknown_op_done: got pending=%0d, required 0", sb.size());
        end
        n_checks++;
        if (frame_error !== 1'b1) begin
            n_fail++;
            $display("FAIL unknown_op_error: got %b, required 1", frame_error);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] rx;
        do_reset();
        spi_byte(8'h12, 8, rx);
        spi_byte(8'h34, 8, rx);
        spi_byte(8'h01, 8, rx);
        rst = 1'b1;
        repeat (2) @(negedge system_clock);
        n_checks++;
        if ({MISO, mem_we, clk_div_we, spike_we, debug_we, rd_req, spi_instruction_done, frame_error} !== 8'h00 ||
            mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got flags=%b addr=%h data=%h, required all 0",
                     {MISO, mem_we, clk_div_we, spike_we, debug_we, rd_req, spi_instruction_done, frame_error},
                     mem_addr, mem_wdata);
        end
        rst = 1'b0;
        repeat (4) @(negedge system_clock);
        sb.push_back('{4'b1000, 8'h56, 8'h99});
        spi_frame(8'h00, 8'h56, 8'h01, 8'h99, rx);
        repeat (GAP) @(negedge system_clock);
        n_checks++;
        if (sb.size() != 0 || frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_recover: got pending=%0d err=%b, required 0/0", sb.size(), frame_error);
        end
    endtask

    task automatic test_stall();
        logic [7:0] rx;
        do_reset();
        spi_byte(8'h00, 8, rx);
        spi_byte(8'h40, 8, rx);
        repeat (100) @(negedge system_clock);
`ifdef SPI_TIMEOUT_EN
        n_checks++;
        if (frame_error !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_abort: got err=%b pending=%0d, required 1/0", frame_error, sb.size());
        end
        sb.push_back('{4'b1000, 8'h41, 8'h44});
        spi_frame(8'h00, 8'h41, 8'h01, 8'h44, rx);
        repeat (GAP) @(negedge system_clock);
        n_checks++;
        if (sb.size() != 0 || mem_addr !== 8'h41) begin
            n_fail++;
            $display("FAIL timeout_recover: got pending=%0d addr=%h, required 0/41", sb.size(), mem_addr);
        end
`else
        sb.push_back('{4'b1000, 8'h40, 8'h33});
        spi_byte(8'h01, 8, rx);
        spi_byte(8'h33, 8, rx);
        repeat (GAP) @(negedge system_clock);
        n_checks++;
        if (sb.size() != 0 || frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_no_timeout: got pending=%0d err=%b, required 0/0", sb.size(), frame_error);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] rx;
        logic [7:0] ops [6] = '{8'h01, 8'h05, 8'h07, 8'h09, 8'h01, 8'h09};
        logic [7:0] a, d;
        logic [3:0] s;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            case (ops[i])
                8'h01:   s = 4'b1000;
                8'h05:   s = 4'b0100;
                8'h07:   s = 4'b0010;
                default: s = 4'b0001;
            endcase
            sb.push_back('{s, a, d});
            spi_frame(8'($urandom_range(0, 255)), a, ops[i], d, rx);
        end
        repeat (GAP) @(negedge system_clock);
        n_checks++;
        if (sb.size() != 0 || frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got pending=%0d err=%b, required 0/0", sb.size(), frame_error);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
        test_reset();
        test_write();
        test_strobes();
        test_read();
        test_short_byte();
        test_saturation();
        test_unknown_opcode();
        test_reset_midframe();
        test_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_cmd_responder.md
Name: spi_cmd_responder

Overview:
- SPI-slave command responder for the spiking network configuration path.
- Deserialises 4-byte SPI frames (addr_msb, addr_lsb, instruction, data) from the external host, decodes the instruction and issues single-cycle write strobes to the parameter memory, clk_div, input-spike and debug-config registers.
- Also serves a one-byte memory read back on MISO.
- Runs entirely in the system_clock domain; SCLK, MOSI and SS are oversampled.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for SCLK/MOSI/SS (legal values 2-3).
- ADDR_W, 8, width of the memory address forwarded downstream (taken from addr_lsb).
- TIMEOUT_CYCLES, 4096, system_clock cycles of SS-high inactivity before the frame aborts (used only with the optional feature).

Ports:
- system_clock  in  1  system clock, ≥5× SCLK frequency
- rst  in  1  asynchronous, active-high reset
- SCLK  in  1  SPI clock, mode 0, MSB first
- MOSI  in  1  SPI data in
- SS  in  1  active-low select, framing exactly one byte
- MISO  out  1  SPI data out
- mem_addr  out  ADDR_W  target address (addr_lsb)
- mem_wdata  out  8  data byte for all write strobes
- mem_we  out  1  memory write strobe (instr 0x01)
- clk_div_we  out  1  clk_div register write (instr 0x05)
- spike_we  out  1  input-spike register write (instr 0x07)
- debug_we  out  1  debug-config write (instr 0x09)
- rd_req  out  1  memory read request (instr 0x00)
- rd_data  in  8  memory read data, valid 1 cycle after rd_req
- spi_instruction_done  out  1  1-cycle pulse at frame completion
- frame_error  out  1  sticky; set on a short byte or an unknown opcode

Behaviour:
- Reset: all outputs are 0 except MISO=0. FSM=S_MSB, bit counter=0, shift registers=0, frame_error=0.
- Input conditioning:
  - SCLK, MOSI and SS pass through SYNC_STAGES flip-flops.
  - Edges are detected on the synchronised SCLK and SS.
  - MOSI is sampled on a detected SCLK rise only while synced SS=0. The bit shifts in at the LSB, so the first bit received ends as bit7.
- Byte completion:
  - On a synced SS rise with bit count=8, the byte is accepted.
  - With bit count≠8 (including 0 after a bare SS pulse), the byte is discarded, the FSM returns to S_MSB and frame_error is set.
  - The bit counter clears on every SS rise.
  - SCLK edges beyond 8 in one SS window are ignored; the count saturates at 8.
- FSM, advancing on accepted bytes:
  - S_MSB: captures addr_msb, which is ignored for decode.
  - S_LSB: captures mem_addr.
  - S_INSTR: captures the opcode. For opcode 0x00, rd_req pulses 1 cycle after acceptance and rd_data loads the TX shift register the following cycle.
  - S_DATA: captures mem_wdata, then goes to S_EXEC.
  - S_EXEC (1 cycle): pulses the decoded strobe and spi_instruction_done, then returns to S_MSB.
- Opcode decode:
  - 0x00: no write strobe in S_EXEC.
  - Any opcode other than 0x00/01/05/07/09: the frame completes, spi_instruction_done still pulses, no strobe fires and frame_error is set.
- Latency: strobes assert 2 cycles after the synced SS rise of the data byte. mem_addr and mem_wdata are held stable until the next frame's LSB/data byte.
- MISO:
  - In S_DATA with opcode 0x00, MISO drives TX bit7 from the synced SS fall, then shifts left after each detected SCLK rise. The master samples bit n on rising edge n+1; the data is held ≥3 system clocks past that edge.
  - In all other states MISO=0.
- Strobes are mutually exclusive; at most one is high in any cycle.
- Reset mid-frame returns to S_MSB immediately with no strobe. The host's next byte is treated as addr_msb.
- frame_error clears only on rst.

Optional Feature:
- Macro SPI_TIMEOUT_EN.
- Defined:
  - A counter runs while the FSM≠S_MSB and synced SS=1, and clears on each SS fall.
  - When the count reaches TIMEOUT_CYCLES, the FSM returns to S_MSB, partial state is discarded, no strobe or done pulse fires, and frame_error is set.
- Undefined: there is no counter, and the FSM waits indefinitely between bytes.

Test Plan:
- Write frame 12,34,01,A5 -> mem_we 1-cycle pulse, mem_addr=0x34, mem_wdata=0xA5; spi_instruction_done pulses in the same cycle; no other strobe fires.
- Frames 00,06,05,B6 / 00,01,07,DC / 00,A3,09,D8 -> clk_div_we, spike_we and debug_we fire respectively with data B6/DC/D8 and addresses 06/01/A3.
- Read frame 45,34,00,00 with rd_data=0x3C -> rd_req pulses once after the instruction byte; MISO bits sampled on the data byte's SCLK rises = 0,0,1,1,1,1,0,0; no write strobe fires.
- Short byte (SS high after 5 bits) during the LSB byte -> frame_error=1, FSM back to S_MSB. A following full frame 00,10,01,77 then writes 0x77 to address 0x10 correctly.
- Unknown opcode 0x03 -> spi_instruction_done pulses, no strobe fires, frame_error=1.
- rst asserted after the instruction byte of a write frame -> no mem_we and all outputs 0. With SPI_TIMEOUT_EN and TIMEOUT_CYCLES=64, stalling 100 cycles after addr_lsb aborts the frame with no strobe and sets frame_error.
